// File: rtl/btb_pkg.sv
// ============================================================================
// btb_pkg : shared types and defaults for the BTB update controller
// Rev 1.0
// ============================================================================
`default_nettype none

package btb_pkg;

    localparam int DEFAULT_ENTRY_ADDR_LEN = 12;
    // Queue fields are sized for the widest legal index/tag; unused MSBs are constant.
    localparam int FIELD_W = 30;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } btb_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] index;
        logic [FIELD_W-1:0] tag;
        logic [31:0]        target;
        logic               taken;
    } btb_upd_t;

    function automatic int tag_len(input int entry_addr_len);
        return 30 - entry_addr_len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_upd_fifo.sv
// ============================================================================
// btb_upd_fifo : power-of-two update queue with synchronous flush
// Rev 1.0
// ============================================================================
`default_nettype none

module btb_upd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  T            push_data,
    input  logic        pop,
    output T            pop_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A pop in the same edge frees the slot, so a full queue may still accept.
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/btb_update_ctrl.sv
// ============================================================================
// btb_update_ctrl : queues EX branch updates into BTB writes; invalidate-all walk.
// Optional statistics counters with macro BTB_CTRL_STATS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int  ENTRY_ADDR_LEN = DEFAULT_ENTRY_ADDR_LEN,
    parameter int  QUEUE_DEPTH    = 4,
    localparam int TAG_LEN        = tag_len(ENTRY_ADDR_LEN),
    localparam int QAW            = $clog2(QUEUE_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      upd_valid_EX,
    input  logic [31:0]               upd_pc_EX,
    input  logic [31:0]               upd_target_EX,
    input  logic                      upd_taken_EX,
    input  logic                      upd_pred_en_EX,
    input  logic                      flush_req,
    output logic                      upd_ready_EX,
    output logic                      flush_busy,
    output logic                      btb_we,
    output logic [ENTRY_ADDR_LEN-1:0] btb_waddr,
    output logic [TAG_LEN-1:0]        btb_wtag,
    output logic [31:0]               btb_wtarget,
    output logic                      btb_wvalid,
    output logic                      btb_wtaken
`ifdef BTB_CTRL_STATS_EN
    ,
    output logic [31:0]               pred_right_cnt,
    output logic [31:0]               pred_wrong_cnt,
    output logic [31:0]               drop_cnt
`endif
);

    btb_state_e                r_state, w_nxt_state;
    logic [ENTRY_ADDR_LEN-1:0] r_walk, w_nxt_walk;
    logic                      w_nxt_we, w_nxt_wvalid, w_nxt_wtaken;
    logic [ENTRY_ADDR_LEN-1:0] w_nxt_waddr;
    logic [TAG_LEN-1:0]        w_nxt_wtag;
    logic [31:0]               w_nxt_wtarget;
    logic                      w_push, w_pop, w_qflush, w_full, w_empty;
    logic [QAW:0]              w_q_count;
    btb_upd_t                  w_entry, w_head;
    logic                      w_unused_bits;

    assign w_entry.index  = FIELD_W'(upd_pc_EX[ENTRY_ADDR_LEN+1:2]);
    assign w_entry.tag    = FIELD_W'(upd_pc_EX[31:32-TAG_LEN]);
    assign w_entry.target = upd_target_EX;
    assign w_entry.taken  = upd_taken_EX;

    assign upd_ready_EX = !w_full && (r_state == ST_IDLE);
    assign flush_busy   = (r_state == ST_FLUSH);
    assign w_unused_bits = ^{upd_pc_EX[1:0], w_q_count,
                             w_head.index[FIELD_W-1:ENTRY_ADDR_LEN],
                             w_head.tag[FIELD_W-1:TAG_LEN]};

    btb_upd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (btb_upd_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_qflush),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_walk  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_walk  <= w_nxt_walk;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_walk    = r_walk;
        w_nxt_we      = 1'b0;
        w_nxt_waddr   = btb_waddr;
        w_nxt_wtag    = btb_wtag;
        w_nxt_wtarget = btb_wtarget;
        w_nxt_wvalid  = btb_wvalid;
        w_nxt_wtaken  = btb_wtaken;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_qflush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush_req) begin
                    w_qflush    = 1'b1;
                    w_nxt_state = ST_FLUSH;
                    w_nxt_walk  = '0;
                end else begin
                    w_push = upd_valid_EX && upd_ready_EX;
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_nxt_we      = 1'b1;
                        w_nxt_waddr   = w_head.index[ENTRY_ADDR_LEN-1:0];
                        w_nxt_wtag    = w_head.tag[TAG_LEN-1:0];
                        w_nxt_wtarget = w_head.target;
                        w_nxt_wvalid  = 1'b1;
                        w_nxt_wtaken  = w_head.taken;
                    end
                end
            end
            ST_FLUSH: begin
                w_nxt_we      = 1'b1;
                w_nxt_waddr   = r_walk;
                w_nxt_wtag    = '0;
                w_nxt_wtarget = '0;
                w_nxt_wvalid  = 1'b0;
                w_nxt_wtaken  = 1'b0;
                // The current index is still written on a restart edge.
                if (flush_req) begin
                    w_nxt_walk = '0;
                end else if (r_walk == '1) begin
                    w_nxt_walk  = '0;
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_walk = r_walk + 1'b1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_we      <= 1'b0;
            btb_waddr   <= '0;
            btb_wtag    <= '0;
            btb_wtarget <= '0;
            btb_wvalid  <= 1'b0;
            btb_wtaken  <= 1'b0;
        end else begin
            btb_we      <= w_nxt_we;
            btb_waddr   <= w_nxt_waddr;
            btb_wtag    <= w_nxt_wtag;
            btb_wtarget <= w_nxt_wtarget;
            btb_wvalid  <= w_nxt_wvalid;
            btb_wtaken  <= w_nxt_wtaken;
        end
    end

`ifdef BTB_CTRL_STATS_EN
    logic [31:0] w_drop_inc;

    // On a flush edge everything queued plus any same-edge update is discarded.
    always_comb begin
        w_drop_inc = 32'(upd_valid_EX && !upd_ready_EX);
        if (r_state == ST_IDLE && flush_req)
            w_drop_inc = 32'(w_q_count) + 32'(upd_valid_EX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_right_cnt <= '0;
            pred_wrong_cnt <= '0;
            drop_cnt       <= '0;
        end else begin
            if (upd_valid_EX) begin
                if (upd_taken_EX ^ upd_pred_en_EX) pred_wrong_cnt <= pred_wrong_cnt + 32'd1;
                else                                pred_right_cnt <= pred_right_cnt + 32'd1;
            end
            drop_cnt <= drop_cnt + w_drop_inc;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
// ============================================================================
// tb_btb_update_ctrl : scoreboard bench for btb_update_ctrl (ENTRY_ADDR_LEN=4)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btb_update_ctrl;

    localparam int EAL = 4;
    localparam int TL  = 26;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           upd_valid_EX = 1'b0;
    logic [31:0]    upd_pc_EX = '0;
    logic [31:0]    upd_target_EX = '0;
    logic           upd_taken_EX = 1'b0;
    logic           upd_pred_en_EX = 1'b0;
    logic           flush_req = 1'b0;
    logic           upd_ready_EX, flush_busy, btb_we, btb_wvalid, btb_wtaken;
    logic [EAL-1:0] btb_waddr;
    logic [TL-1:0]  btb_wtag;
    logic [31:0]    btb_wtarget;
`ifdef BTB_CTRL_STATS_EN
    logic [31:0]    pred_right_cnt, pred_wrong_cnt, drop_cnt;
`endif

    typedef struct {
        logic [EAL-1:0] addr;
        logic [TL-1:0]  tag;
        logic [31:0]    tgt;
        logic           vld;
        logic           tkn;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_cnt = 0;
    int  exp_right = 0, exp_wrong = 0, exp_drop = 0;
    int  n, w0;

    btb_update_ctrl #(
        .ENTRY_ADDR_LEN (EAL),
        .QUEUE_DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upd_valid_EX   (upd_valid_EX),
        .upd_pc_EX      (upd_pc_EX),
        .upd_target_EX  (upd_target_EX),
        .upd_taken_EX   (upd_taken_EX),
        .upd_pred_en_EX (upd_pred_en_EX),
        .flush_req      (flush_req),
        .upd_ready_EX   (upd_ready_EX),
        .flush_busy     (flush_busy),
        .btb_we         (btb_we),
        .btb_waddr      (btb_waddr),
        .btb_wtag       (btb_wtag),
        .btb_wtarget    (btb_wtarget),
        .btb_wvalid     (btb_wvalid),
        .btb_wtaken     (btb_wtaken)
`ifdef BTB_CTRL_STATS_EN
        ,
        .pred_right_cnt (pred_right_cnt),
        .pred_wrong_cnt (pred_wrong_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef BTB_CTRL_STATS_EN
        check({tag, "_right"}, pred_right_cnt, exp_right);
        check({tag, "_wrong"}, pred_wrong_cnt, exp_wrong);
        check({tag, "_drop"},  drop_cnt,       exp_drop);
`else
        n = n;
`endif
    endtask

    // writes=1 pushes the BTB write this update must eventually produce.
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                       input logic pe, input logic exp_rdy, input logic writes);
        wr_t e;
        check("ready", upd_ready_EX, exp_rdy);
        upd_valid_EX   = 1'b1;
        upd_pc_EX      = pc;
        upd_target_EX  = tgt;
        upd_taken_EX   = tk;
        upd_pred_en_EX = pe;
        if (writes) begin
            e.addr = pc[5:2];
            e.tag  = pc[31:6];
            e.tgt  = tgt;
            e.vld  = 1'b1;
            e.tkn  = tk;
            exp_q.push_back(e);
        end
        if (tk ^ pe) exp_wrong++;
        else         exp_right++;
        if (!exp_rdy) exp_drop++;
        tick();
        upd_valid_EX = 1'b0;
    endtask

    task automatic push_walk(input int cnt);
        wr_t e;
        for (int i = 0; i < cnt; i++) begin
            e.addr = EAL'(i);
            e.tag  = '0;
            e.tgt  = '0;
            e.vld  = 1'b0;
            e.tkn  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && btb_we) begin
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexp_wr", 64'(btb_we), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {btb_wvalid, btb_wtaken, btb_waddr}, {e.vld, e.tkn, e.addr});
                check("wr_tag", btb_wtag, e.tag);
                check("wr_tgt", btb_wtarget, e.tgt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", btb_we, 0);
        check("rst_busy", flush_busy, 0);
        chk_stats("rst");
        #2 rst_n = 1'b1;
        tick();
        check("rel_ready", upd_ready_EX, 1);
        check("rel_we", btb_we, 0);

        // single update: write appears after the second edge
        upd(32'h0000_0010, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b1);
        check("lat_k", btb_we, 0);
        tick();
        check("lat_k1", btb_we, 1);
        check("lat_addr", btb_waddr, 4);
        repeat (3) tick();

        for (int i = 0; i < 6; i++)
            upd(32'h0000_1000 + 32'(i) * 32'h48, 32'h8000_0000 + 32'(i) * 16,
                1'(i), 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        check("b2b_sb", exp_q.size(), 0);
        chk_stats("b2b");

        // flush with a queued entry plus a same-edge update
        w0 = wr_cnt;
        upd(32'h0000_0200, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b0);
        flush_req = 1'b1;
        push_walk(16);
        exp_drop += 2;
        upd(32'h0000_0204, 32'h0000_0304, 1'b0, 1'b0, 1'b1, 1'b0);
        flush_req = 1'b0;
        check("flush_busy0", flush_busy, 1);
        n = 0;
        while (flush_busy && n < 64) begin
            if (n == 3) upd(32'h0000_0208, 32'h0000_0308, 1'b1, 1'b1, 1'b0, 1'b0);
            else        tick();
            n++;
        end
        check("flush_len", n, 16);
        repeat (2) tick();
        check("flush_wr", wr_cnt - w0, 16);
        check("flush_sb", exp_q.size(), 0);
        chk_stats("flush");

        // restart the walk when it reaches index 9
        w0 = wr_cnt;
        flush_req = 1'b1;
        push_walk(10);
        push_walk(16);
        tick();
        flush_req = 1'b0;
        repeat (9) tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        while (flush_busy && n < 64) begin
            tick();
            n++;
        end
        check("restart_len", n, 16);
        repeat (2) tick();
        check("restart_wr", wr_cnt - w0, 26);
        check("restart_sb", exp_q.size(), 0);

        // asynchronous reset at walk index 5
        flush_req = 1'b1;
        push_walk(16);
        tick();
        flush_req = 1'b0;
        repeat (5) tick();
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_right = 0;
        exp_wrong = 0;
        exp_drop  = 0;
        check("arst_we", btb_we, 0);
        check("arst_busy", flush_busy, 0);
        chk_stats("arst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_we", btb_we, 0);
        check("post_rst_ready", upd_ready_EX, 1);

        // prediction outcome patterns after reset
        upd(32'h0000_0ABC, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b1);
        upd(32'hFFFF_FFC0, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 1'b1);
        upd(32'h1357_9BDC, 32'hDEAD_BEEC, 1'b1, 1'b0, 1'b1, 1'b1);
        upd(32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) tick();
        chk_stats("pred");
        check("end_sb", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 The block SHALL have parameter ENTRY_ADDR_LEN, default 12, giving BTB index width (ENTRY_SIZE = 2**ENTRY_ADDR_LEN, TAG_LEN = 30-ENTRY_ADDR_LEN).
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 4, giving update-queue entries (power of two, >=2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these inputs: upd_valid_EX  in  1  resolved branch in EX; upd_pc_EX  in  32  branch PC; upd_target_EX  in  32  resolved target; upd_taken_EX  in  1  actual outcome; upd_pred_en_EX  in  1  prediction made in IF; flush_req  in  1  invalidate-all pulse.
REQ-005 The block SHALL have these outputs: upd_ready_EX  out  1  queue can accept; flush_busy  out  1  walk in progress; btb_we  out  1  BTB write strobe; btb_waddr  out  ENTRY_ADDR_LEN  index; btb_wtag  out  TAG_LEN  tag; btb_wtarget  out  32  target; btb_wvalid  out  1  entry valid bit; btb_wtaken  out  1  prediction bit.

Function
REQ-006 Index SHALL be upd_pc_EX[ENTRY_ADDR_LEN+1:2]; tag SHALL be upd_pc_EX[31:32-TAG_LEN].
REQ-007 An update SHALL be accepted at a rising edge when upd_valid_EX=1 and upd_ready_EX=1; upd_ready_EX SHALL be 1 only when the queue is not full and the state is IDLE.
REQ-008 An update presented while upd_ready_EX=0 SHALL be dropped (EX never stalls).
REQ-009 FSM states SHALL be IDLE and FLUSH.
REQ-010 In IDLE with a non-empty queue, each edge SHALL pop the head into the registered write outputs with btb_we=1, btb_wvalid=1, btb_wtaken=head taken; an empty queue SHALL give btb_we=0 next cycle.
REQ-011 Latency: an update accepted at edge k into an empty queue SHALL drive btb_we in the cycle after edge k+1; drain throughput SHALL be one write per cycle.
REQ-012 Simultaneous push and pop in the same edge SHALL be allowed even when full; pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-013 flush_req=1 in IDLE SHALL clear the queue (including any same-edge update), load walk index 0 and enter FLUSH.
REQ-014 In FLUSH each edge SHALL drive btb_we=1, btb_waddr=walk index, btb_wvalid=0, btb_wtaken=0, btb_wtag=0, btb_wtarget=0, then increment the index.
REQ-015 After the write of index ENTRY_SIZE-1 the FSM SHALL return to IDLE; a flush therefore occupies exactly ENTRY_SIZE write cycles.
REQ-016 flush_req=1 while in FLUSH SHALL restart the walk at index 0.
REQ-017 flush_busy SHALL be 1 exactly while in FLUSH.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, empty queue, walk index 0, btb_we=0, all write outputs 0, flush_busy=0, upd_ready_EX=1 after release, all counters 0.
REQ-019 Reset asserted mid-FLUSH or with a non-empty queue SHALL discard all pending work; no BTB write SHALL occur in the first cycle after release.

Configuration
REQ-020 With macro BTB_CTRL_STATS_EN defined, outputs pred_right_cnt (32), pred_wrong_cnt (32) and drop_cnt (32) SHALL exist: every edge with upd_valid_EX=1 SHALL increment pred_wrong_cnt if upd_taken_EX^upd_pred_en_EX, else pred_right_cnt; drop_cnt SHALL count each dropped or flush-discarded update; counters SHALL wrap at 2**32.
REQ-021 Without BTB_CTRL_STATS_EN those ports and counters SHALL be absent and all other behaviour unchanged.

Structure
REQ-022 Package btb_pkg SHALL hold ENTRY_ADDR_LEN default, TAG_LEN derivation, the FSM state enum, and the queue-entry struct (index, tag, target, taken).
REQ-023 The queue SHALL be sub-module btb_upd_fifo (parameterised depth and entry type, push/pop/full/empty/flush).

Verification (ENTRY_ADDR_LEN=4, QUEUE_DEPTH=4)
REQ-024 Single update pc=0x0000_0010, target=0x0000_0100, taken=1 -> btb_we=1 two edges later, waddr=4, wtag=0, wtarget=0x100, wvalid=1, wtaken=1.
REQ-025 Six back-to-back updates while an external flush is not active -> all six written in order, one per cycle, upd_ready_EX never low, drop_cnt=0.
REQ-026 flush_req with 3 queued entries -> queue emptied, drop_cnt=3, 16 consecutive writes waddr 0..15 wvalid=0, flush_busy high 16 cycles, then IDLE.
REQ-027 Update during FLUSH -> upd_ready_EX=0, no later write for it, drop_cnt+1; second flush_req at walk index 9 -> walk restarts at 0, total 26 write cycles.
REQ-028 rst_n low at walk index 5 -> btb_we=0 immediately, flush_busy=0, counters 0; after release, new update writes normally.
REQ-029 (STATS_EN) updates with (taken,pred_en)=(1,1),(0,1),(1,0),(0,0) -> pred_right_cnt=2, pred_wrong_cnt=2.
